accum_feeder: RTL and testbench
===============================

ACCUM_FEEDER -- requirements
Module: accum_feeder

Interface
REQ-001 Parameter DATAW, default 32, width of result data word.
REQ-002 Parameter DEPTH, default 64, number of accumulator rows addressable.
REQ-003 Parameter ADDRW, default 6, row address width (log2 DEPTH).
REQ-004 Parameter SUBW, default 8, width of subset-vector count.
REQ-005 Parameter HAZ, default 4, minimum cycle spacing between two issues to the same row address.
REQ-006 Port clk  input  1  sole clock; all logic on rising edge.
REQ-007 Port rst  input  1  asynchronous, active-low reset.
REQ-008 Port i_start  input  1  one-cycle pulse; latches config and begins a job when idle.
REQ-009 Port i_num_rows  input  ADDRW+1  rows per subset, legal 1..DEPTH.
REQ-010 Port i_num_subsets  input  SUBW  subset vectors per input vector, legal 1..2^SUBW-1.
REQ-011 Port s_valid / s_ready / s_data  input/output/input  1/1/DATAW  DPE result stream, valid-ready handshake.
REQ-012 Port m_valid, m_data, m_addr, m_accum, m_last  output  1, DATAW, ADDRW, 1, 1  drive accumulator valid/data/addr/accum/last inputs.
REQ-013 Port o_busy  output  1  job in progress; o_done  output  1  one-cycle job-complete pulse.

Function
REQ-014 FSM states IDLE, RUN, DRAIN; reset state IDLE.
REQ-015 IDLE: s_ready=0; i_start latches i_num_rows/i_num_subsets, clears row and subset counters, enters RUN next cycle.
REQ-016 i_start while not IDLE SHALL be ignored; config inputs are sampled only on accepted start.
REQ-017 RUN: a beat transfers when s_valid && s_ready; each transfer produces exactly one registered m_valid beat the next cycle (latency 1).
REQ-018 Issued beat: m_data = s_data, m_addr = row counter, m_accum = (subset counter != 0), m_last = (subset counter == num_subsets-1).
REQ-019 Row counter increments per transfer, wraps num_rows-1 -> 0 and increments subset counter on wrap.
REQ-020 m_valid SHALL be 0 in every cycle without a transfer in the previous cycle; m_data/m_addr/m_accum/m_last hold last value when m_valid=0.
REQ-021 Hazard: s_ready SHALL be 0 when the current row address equals any address issued within the last HAZ-1 cycles, guaranteeing issue spacing >= HAZ per address.
REQ-022 Hazard tracking covers only valid issued beats; bubble cycles occupy window slots as invalid.
REQ-023 num_rows >= HAZ SHALL incur zero hazard stalls; num_rows=1 SHALL sustain one beat per HAZ cycles.
REQ-024 Transfer of row num_rows-1 in subset num_subsets-1 SHALL move to DRAIN; s_ready=0 from that cycle.
REQ-025 DRAIN: wait HAZ cycles after final issue, then pulse o_done for one cycle and return to IDLE.
REQ-026 o_busy = 1 in RUN and DRAIN, 0 in IDLE, including the o_done cycle returning to IDLE? No: o_busy SHALL be 0 in the o_done cycle.
REQ-027 s_ready SHALL not depend combinationally on s_valid.

Reset
REQ-028 On rst low, asynchronously: state IDLE, counters 0, hazard window cleared, m_valid=0, m_data=0, m_addr=0, m_accum=0, m_last=0, s_ready=0, o_busy=0, o_done=0.
REQ-029 Reset mid-job SHALL abort the job with no further m_valid beats; no partial resume after release.

Structure
REQ-030 Package accum_pkg SHALL hold FSM state enum and default DATAW/ADDRW/SUBW/HAZ constants, shared with accum.
REQ-031 One sub-module accum_hazard_window SHALL implement the HAZ-1-deep address/valid shift register and match compare.

Verification
REQ-032 rows=8, subsets=3, s_valid always 1 -> 24 beats back-to-back, addr 0..7 x3, m_accum 0 for first 8, m_last 1 for last 8, o_done HAZ cycles after last beat.
REQ-033 rows=1, subsets=5 -> beats exactly 4 cycles apart at addr 0, m_accum=0,1,1,1,1, m_last only on 5th.
REQ-034 rows=2, subsets=2, HAZ=4 -> issue at cycles t, t+1, t+4, t+5 (relative), no same-address spacing < 4.
REQ-035 rows=4, subsets=2, random s_valid gaps -> same addr/accum/last sequence as REQ-032 pattern, m_valid never without prior transfer.
REQ-036 Assert rst low after 5 beats of an 8x3 job -> all outputs 0 immediately, next start with rows=2, subsets=1 gives addr 0,1 with m_last=1, m_accum=0.
REQ-037 i_start pulsed during RUN with different config -> ignored; original job completes unchanged.

Source files
------------

// File: rtl/accum_pkg.sv
// Shared types and default sizing for the accumulator feeder slice.
package accum_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } state_t;

    localparam int unsigned ACC_DATAW = 32;
    localparam int unsigned ACC_DEPTH = 64;
    localparam int unsigned ACC_ADDRW = 6;
    localparam int unsigned ACC_SUBW  = 8;
    localparam int unsigned ACC_HAZ   = 4;

endpackage

// File: rtl/accum_hazard_window.sv
// Tracks the row addresses issued over the last HAZ-1 cycles and flags a
// collision with the row about to be issued. HAZ must be at least 2.
module accum_hazard_window
    import accum_pkg::*;
#(
    parameter int unsigned ADDRW = ACC_ADDRW,
    parameter int unsigned HAZ   = ACC_HAZ
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             issue_valid,
    input  logic [ADDRW-1:0] issue_addr,
    input  logic [ADDRW-1:0] cmp_addr,
    output logic             hit
);

    localparam int unsigned SLOTS = HAZ - 1;

    logic [SLOTS-1:0]            slot_v;
    logic [SLOTS-1:0][ADDRW-1:0] slot_a;

    // Shifts every cycle so bubbles age out exactly like real issues.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            slot_v <= '0;
            slot_a <= '0;
        end else begin
            slot_v[0] <= issue_valid;
            slot_a[0] <= issue_addr;
            for (int unsigned i = 1; i < SLOTS; i++) begin
                slot_v[i] <= slot_v[i-1];
                slot_a[i] <= slot_a[i-1];
            end
        end
    end

    always_comb begin
        hit = 1'b0;
        for (int unsigned i = 0; i < SLOTS; i++) begin
            if (slot_v[i] && (slot_a[i] == cmp_addr)) begin
                hit = 1'b1;
            end
        end
    end

endmodule

// File: rtl/accum_feeder.sv
// Feeds DPE result beats into accumulator rows, walking rows per subset and
// stalling the stream whenever a row would be re-issued inside the hazard window.
module accum_feeder
    import accum_pkg::*;
#(
    parameter int unsigned DATAW = ACC_DATAW,
    parameter int unsigned DEPTH = ACC_DEPTH,
    parameter int unsigned ADDRW = ACC_ADDRW,
    parameter int unsigned SUBW  = ACC_SUBW,
    parameter int unsigned HAZ   = ACC_HAZ
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_start,
    input  logic [ADDRW:0]   i_num_rows,
    input  logic [SUBW-1:0]  i_num_subsets,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [DATAW-1:0] s_data,
    output logic             m_valid,
    output logic [DATAW-1:0] m_data,
    output logic [ADDRW-1:0] m_addr,
    output logic             m_accum,
    output logic             m_last,
    output logic             o_busy,
    output logic             o_done
);

    localparam int unsigned CNTW = $clog2(HAZ + 1);

    state_t           state;
    state_t           state_nxt;
    logic [ADDRW:0]   num_rows;
    logic [SUBW-1:0]  num_subsets;
    logic [ADDRW-1:0] row_cnt;
    logic [SUBW-1:0]  sub_cnt;
    logic [CNTW-1:0]  drain_cnt;
    logic             hit;
    logic             xfer;
    logic             last_row;
    logic             last_sub;
    logic             done_nxt;

    assign s_ready  = (state == RUN) && !hit;
    assign xfer     = s_valid && s_ready;
    assign o_busy   = (state != IDLE);
    // Also wrap at the last physical row so an out-of-range row count cannot escape DEPTH.
    assign last_row = ({1'b0, row_cnt} == (num_rows - 1'b1)) || (row_cnt == ADDRW'(DEPTH - 1));
    assign last_sub = (sub_cnt == (num_subsets - 1'b1));

    accum_hazard_window #(
        .ADDRW (ADDRW),
        .HAZ   (HAZ)
    ) u_haz (
        .clk         (clk),
        .rst         (rst),
        .issue_valid (xfer),
        .issue_addr  (row_cnt),
        .cmp_addr    (row_cnt),
        .hit         (hit)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        done_nxt  = 1'b0;
        case (state)
            IDLE: begin
                if (i_start) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (xfer && last_row && last_sub) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                // First DRAIN cycle carries the final beat; done lands HAZ cycles later.
                if (drain_cnt == CNTW'(HAZ - 1)) begin
                    state_nxt = IDLE;
                    done_nxt  = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            num_rows    <= '0;
            num_subsets <= '0;
            row_cnt     <= '0;
            sub_cnt     <= '0;
            drain_cnt   <= '0;
            m_valid     <= 1'b0;
            m_data      <= '0;
            m_addr      <= '0;
            m_accum     <= 1'b0;
            m_last      <= 1'b0;
            o_done      <= 1'b0;
        end else begin
            o_done    <= done_nxt;
            m_valid   <= xfer;
            drain_cnt <= (state == DRAIN) ? drain_cnt + 1'b1 : '0;
            if ((state == IDLE) && i_start) begin
                num_rows    <= i_num_rows;
                num_subsets <= i_num_subsets;
                row_cnt     <= '0;
                sub_cnt     <= '0;
            end
            if (xfer) begin
                m_data  <= s_data;
                m_addr  <= row_cnt;
                m_accum <= (sub_cnt != '0);
                m_last  <= last_sub;
                if (last_row) begin
                    row_cnt <= '0;
                    sub_cnt <= sub_cnt + 1'b1;
                end else begin
                    row_cnt <= row_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_accum_feeder.sv
// Scoreboard bench for accum_feeder: expected beats queued per job, compared as issued.
module tb_accum_feeder;

    localparam int DATAW = 32;
    localparam int DEPTH = 64;
    localparam int ADDRW = 6;
    localparam int SUBW  = 8;
    localparam int HAZ   = 4;

    typedef struct {
        logic [DATAW-1:0] data;
        logic [ADDRW-1:0] addr;
        logic             accum;
        logic             last;
    } exp_t;

    logic             clk;
    logic             rst;
    logic             i_start;
    logic [ADDRW:0]   i_num_rows;
    logic [SUBW-1:0]  i_num_subsets;
    logic             s_valid;
    logic             s_ready;
    logic [DATAW-1:0] s_data;
    logic             m_valid;
    logic [DATAW-1:0] m_data;
    logic [ADDRW-1:0] m_addr;
    logic             m_accum;
    logic             m_last;
    logic             o_busy;
    logic             o_done;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   done_cyc = -1;
    int   last_issue[DEPTH];
    int   beat_cyc[$];
    exp_t exp_q[$];
    exp_t mon_e;
    bit   prev_xfer = 1'b0;

    accum_feeder #(
        .DATAW (DATAW),
        .DEPTH (DEPTH),
        .ADDRW (ADDRW),
        .SUBW  (SUBW),
        .HAZ   (HAZ)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .i_start       (i_start),
        .i_num_rows    (i_num_rows),
        .i_num_subsets (i_num_subsets),
        .s_valid       (s_valid),
        .s_ready       (s_ready),
        .s_data        (s_data),
        .m_valid       (m_valid),
        .m_data        (m_data),
        .m_addr        (m_addr),
        .m_accum       (m_accum),
        .m_last        (m_last),
        .o_busy        (o_busy),
        .o_done        (o_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Output monitor: beats only after a transfer, in scoreboard order, with hazard spacing.
    always @(negedge clk) begin
        if (!rst) begin
            prev_xfer = 1'b0;
        end else begin
            check("m_valid_gate", 64'(m_valid), 64'(prev_xfer));
            if (m_valid) begin
                check("beat_expected", 64'(exp_q.size() != 0), 64'd1);
                if (exp_q.size() != 0) begin
                    mon_e = exp_q.pop_front();
                    check("m_data", 64'(m_data), 64'(mon_e.data));
                    check("m_addr", 64'(m_addr), 64'(mon_e.addr));
                    check("m_accum", 64'(m_accum), 64'(mon_e.accum));
                    check("m_last", 64'(m_last), 64'(mon_e.last));
                end
                if (last_issue[m_addr] >= 0) begin
                    check("haz_spacing", 64'((cyc - last_issue[m_addr]) >= HAZ), 64'd1);
                end
                last_issue[m_addr] = cyc;
                beat_cyc.push_back(cyc);
            end
            if (o_done) begin
                check("busy_at_done", 64'(o_busy), 64'd0);
                done_cyc = cyc;
            end
            prev_xfer = s_valid && s_ready;
        end
    end

    task automatic run_job(input int rows, input int subs, input int valid_pct,
                           input int limit, input int restart_at, input bit wait_done);
        int n;
        int k;
        int budget;
        bit restarted;
        exp_t e;
        logic [DATAW-1:0] base;
        n = rows * subs;
        if (limit > 0 && limit < n) n = limit;
        beat_cyc.delete();
        done_cyc = -1;
        for (int a = 0; a < DEPTH; a++) last_issue[a] = -1;
        base = $urandom;
        for (int i = 0; i < n; i++) begin
            e.data  = base + DATAW'(i);
            e.addr  = ADDRW'(i % rows);
            e.accum = (i / rows) != 0;
            e.last  = (i / rows) == subs - 1;
            exp_q.push_back(e);
        end
        @(posedge clk); #1;
        i_start       = 1'b1;
        i_num_rows    = (ADDRW+1)'(rows);
        i_num_subsets = SUBW'(subs);
        @(posedge clk); #1;
        i_start       = 1'b0;
        i_num_rows    = (ADDRW+1)'($urandom_range(63) + 1);
        i_num_subsets = 8'd200;
        k = 0;
        budget = 0;
        restarted = 1'b0;
        while (k < n && budget < 2000) begin
            s_valid = ($urandom_range(99) < valid_pct);
            s_data  = base + DATAW'(k);
            if (restart_at >= 0 && k == restart_at && !restarted) begin
                restarted     = 1'b1;
                i_start       = 1'b1;
                i_num_rows    = 7'd1;
                i_num_subsets = 8'd1;
            end else begin
                i_start = 1'b0;
            end
            @(negedge clk);
            if (s_valid && s_ready) k++;
            @(posedge clk); #1;
            budget++;
        end
        s_valid = 1'b0;
        i_start = 1'b0;
        check("xfer_count", 64'(k), 64'(n));
        if (wait_done) begin
            budget = 0;
            while (done_cyc < 0 && budget < 50) begin
                @(negedge clk);
                budget++;
            end
            check("done_seen", 64'(done_cyc >= 0), 64'd1);
            if (done_cyc >= 0 && beat_cyc.size() > 0) begin
                check("done_delay", 64'(done_cyc - beat_cyc[$]), 64'(HAZ));
            end
            check("beat_count", 64'(beat_cyc.size()), 64'(n));
            check("queue_drained", 64'(exp_q.size()), 64'd0);
        end
    endtask

    initial begin
        rst           = 1'b1;
        i_start       = 1'b0;
        i_num_rows    = '0;
        i_num_subsets = '0;
        s_valid       = 1'b0;
        s_data        = '0;
        #3 rst = 1'b0;
        #1 check("reset_outputs",
                 64'({m_valid, m_data, m_addr, m_accum, m_last, s_ready, o_busy, o_done}), 64'd0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;

        // 8x3 streaming with no gaps: no stalls at all
        run_job(8, 3, 100, 0, -1, 1'b1);
        if (beat_cyc.size() == 24) check("b2b_span", 64'(beat_cyc[23] - beat_cyc[0]), 64'd23);

        // single row: one beat every HAZ cycles
        run_job(1, 5, 100, 0, -1, 1'b1);
        if (beat_cyc.size() == 5) begin
            for (int i = 1; i < 5; i++) check("r1_spacing", 64'(beat_cyc[i] - beat_cyc[i-1]), 64'(HAZ));
        end

        // two rows: issues at t, t+1, t+4, t+5
        run_job(2, 2, 100, 0, -1, 1'b1);
        if (beat_cyc.size() == 4) begin
            check("r2_rel1", 64'(beat_cyc[1] - beat_cyc[0]), 64'd1);
            check("r2_rel2", 64'(beat_cyc[2] - beat_cyc[0]), 64'd4);
            check("r2_rel3", 64'(beat_cyc[3] - beat_cyc[0]), 64'd5);
        end

        // random source gaps
        run_job(4, 2, 60, 0, -1, 1'b1);

        // start pulse mid-job must be ignored
        run_job(4, 2, 100, 0, 2, 1'b1);

        // reset in the middle of an 8x3 job after 5 beats
        run_job(8, 3, 100, 5, -1, 1'b0);
        @(negedge clk);
        #2 rst = 1'b0;
        #1 check("mid_reset_outputs",
                 64'({m_valid, m_data, m_addr, m_accum, m_last, s_ready, o_busy, o_done}), 64'd0);
        check("mid_reset_q", 64'(exp_q.size()), 64'd0);
        exp_q.delete();
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        repeat (3) @(negedge clk);
        check("no_resume_busy", 64'(o_busy), 64'd0);
        run_job(2, 1, 100, 0, -1, 1'b1);

        repeat (2) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
